// File: rtl/adder.sv
// Registered unsigned WIDTH-bit adder with carry-out, built from a per-bit full-adder chain.
// Define ADDER_PIPE_EN to split the chain into two register stages (latency 2 instead of 1).
module adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One full-adder cell: returns {carry_out, sum_bit} from generate/propagate.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    logic g;
    logic p;
    g = x & y;
    p = x ^ y;
    return {g | (p & ci), p ^ ci};
  endfunction

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

`ifdef ADDER_PIPE_EN
  localparam int H = WIDTH / 2;

  logic [H-1:0]       lo_d;
  logic               clo_d;
  logic               c1;
  logic [H-1:0]       lo_p1_q;
  logic               clo_p1_q;
  logic [WIDTH-H-1:0] ahi_p1_q;
  logic [WIDTH-H-1:0] bhi_p1_q;
  logic [WIDTH-H-1:0] hi_d;
  logic               c2;

  // Stage p0 -> p1: low half of the chain, high operand halves carried along.
  always_comb begin
    lo_d = '0;
    c1   = 1'b0;
    for (int i = 0; i < H; i++) begin
      {c1, lo_d[i]} = fa(a[i], b[i], c1);
    end
    clo_d = c1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_p1_q  <= '0;
      clo_p1_q <= 1'b0;
      ahi_p1_q <= '0;
      bhi_p1_q <= '0;
    end else begin
      lo_p1_q  <= lo_d;
      clo_p1_q <= clo_d;
      ahi_p1_q <= a[WIDTH-1:H];
      bhi_p1_q <= b[WIDTH-1:H];
    end
  end

  // Stage p1 -> p2: high half seeded with the registered intermediate carry.
  always_comb begin
    hi_d = '0;
    c2   = clo_p1_q;
    for (int i = 0; i < WIDTH - H; i++) begin
      {c2, hi_d[i]} = fa(ahi_p1_q[i], bhi_p1_q[i], c2);
    end
    sum_d  = {hi_d, lo_p1_q};
    cout_d = c2;
  end
`else
  logic c0;

  // Stage p0 -> p1: full ripple chain in one cycle.
  always_comb begin
    sum_d = '0;
    c0    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      {c0, sum_d[i]} = fa(a[i], b[i], c0);
    end
    cout_d = c0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_adder.sv
// Directed and random checks of the registered adder; expected {cout,sum} tracked through
// a latency-deep expectation pipe that reset clears.
module tb_adder;

`ifdef ADDER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       cout;

  int n_vec  = 0;
  int n_miss = 0;

  logic [8:0] mdl [LAT];

  logic [7:0] va [4];
  logic [7:0] vb [4];
  logic [8:0] ve [4];

  always #5 clk = ~clk;

  adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cout)
  );

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got {cout,sum}=%0d (0x%03h), expected %0d (0x%03h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the expectation pipe at the edge, check mid-cycle.
  task automatic cycle(input logic r, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [8:0] exp, input string tag);
    rst = r;
    a   = ai;
    b   = bi;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < LAT; i++) mdl[i] = '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) mdl[i] = mdl[i-1];
      mdl[0] = exp;
    end
    @(negedge clk);
    chk(tag, {cout, sum}, mdl[LAT-1]);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    for (int i = 0; i < LAT; i++) mdl[i] = '0;

    va[0] = 8'd15;  vb[0] = 8'd10;  ve[0] = 9'd25;
    va[1] = 8'd127; vb[1] = 8'd127; ve[1] = 9'd254;
    va[2] = 8'd200; vb[2] = 8'd100; ve[2] = 9'h12C;
    va[3] = 8'd255; vb[3] = 8'd1;   ve[3] = 9'h100;

    // Reset held two cycles with all-ones operands.
    cycle(1'b1, 8'hFF, 8'hFF, 9'd0, "rst_hold0");
    cycle(1'b1, 8'hFF, 8'hFF, 9'd0, "rst_hold1");

    // Isolated vectors, each flushed with idle zero operands.
    for (int v = 0; v < 4; v++) begin
      cycle(1'b0, va[v], vb[v], ve[v], $sformatf("single%0d", v));
      for (int k = 0; k < LAT; k++) cycle(1'b0, 8'd0, 8'd0, 9'd0, $sformatf("single%0d_flush", v));
    end

    // Back-to-back stream, one new operand pair per cycle.
    for (int v = 0; v < 4; v++) cycle(1'b0, va[v], vb[v], ve[v], $sformatf("stream%0d", v));
    for (int k = 0; k < LAT; k++) cycle(1'b0, 8'd1, 8'd2, 9'd3, "stream_tail");

    // Reset mid-stream: in-flight 255+255 is discarded, 200+100 during reset is ignored.
    cycle(1'b0, 8'd255, 8'd255, 9'd510, "midrst_pre");
    cycle(1'b1, 8'd200, 8'd100, 9'd0,   "midrst_rst");
    cycle(1'b0, 8'd15,  8'd10,  9'd25,  "midrst_post0");
    cycle(1'b0, 8'd255, 8'd1,   9'h100, "midrst_post1");
    for (int k = 0; k < LAT; k++) cycle(1'b0, 8'd0, 8'd0, 9'd0, "midrst_flush");

    // Random pairs against the golden sum.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      cycle(1'b0, ra, rb, {1'b0, ra} + {1'b0, rb}, "random");
    end
    for (int k = 0; k < LAT; k++) cycle(1'b0, 8'd0, 8'd0, 9'd0, "random_flush");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
